ofs_plat_axi_mem_lite_csr_bridge: RTL and testbench

OFS_PLAT_AXI_MEM_LITE_CSR_BRIDGE -- requirements
Module: ofs_plat_axi_mem_lite_csr_bridge

---
 rtl/ofs_plat_axi_mem_pkg.sv | 20 ++
 rtl/ofs_plat_axi_mem_lite_csr_bridge_if.sv | 66 ++++++
 rtl/ofs_plat_axi_mem_lite_csr_bridge.sv | 158 +++++++++++++++
 tb/tb_ofs_plat_axi_mem_lite_csr_bridge.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofs_plat_axi_mem_pkg.sv
// Shared types for the AXI-Lite memory platform blocks.
// Holds the CSR bridge FSM encoding and the AXI response codes.
package ofs_plat_axi_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CSR_REQ,
        CSR_WAIT,
        B_RSP,
        R_RSP
    } csr_bridge_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/ofs_plat_axi_mem_lite_csr_bridge_if.sv
// Bundle of the AXI-Lite channels and the CSR request/response pair
// that surround the AXI-Lite to CSR bridge.
interface ofs_plat_axi_mem_lite_csr_bridge_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64
) ();

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;

    logic                  csr_req_valid;
    logic                  csr_req_ready;
    logic                  csr_req_write;
    logic [ADDR_WIDTH-1:0] csr_req_addr;
    logic [DATA_WIDTH-1:0] csr_req_wdata;
    logic [STRB_WIDTH-1:0] csr_req_wstrb;
    logic                  csr_rsp_valid;
    logic [DATA_WIDTH-1:0] csr_rsp_rdata;
    logic                  csr_rsp_error;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, rready,
        output awready, wready, bvalid, bresp,
        output arready, rvalid, rdata, rresp
    );

    modport csr_host (
        output csr_req_valid, csr_req_write, csr_req_addr,
        output csr_req_wdata, csr_req_wstrb,
        input  csr_req_ready, csr_rsp_valid, csr_rsp_rdata,
        input  csr_rsp_error
    );

    modport csr_dev (
        input  csr_req_valid, csr_req_write, csr_req_addr,
        input  csr_req_wdata, csr_req_wstrb,
        output csr_req_ready, csr_rsp_valid, csr_rsp_rdata,
        output csr_rsp_error
    );

endinterface

// File: rtl/ofs_plat_axi_mem_lite_csr_bridge.sv
// AXI-Lite slave to simple CSR request/response bridge.
// Carries one transaction at a time; ties alternate write/read.
module ofs_plat_axi_mem_lite_csr_bridge
    import ofs_plat_axi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,

    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,

    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp,

    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDR_WIDTH-1:0]   araddr,

    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,

    output logic                    csr_req_valid,
    input  logic                    csr_req_ready,
    output logic                    csr_req_write,
    output logic [ADDR_WIDTH-1:0]   csr_req_addr,
    output logic [DATA_WIDTH-1:0]   csr_req_wdata,
    output logic [DATA_WIDTH/8-1:0] csr_req_wstrb,

    input  logic                    csr_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   csr_rsp_rdata,
    input  logic                    csr_rsp_error
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $error("DATA_WIDTH must be 32 or 64");
    end

    csr_bridge_state_e state_q;
    csr_bridge_state_e state_d;

    logic                  last_was_write_q;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic [1:0]            bresp_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic wr_elig;
    logic rd_elig;
    logic can_grant;
    logic grant_wr;
    logic grant_rd;
    logic rsp_take;

    // Grants are suppressed while reset is high so no input is sampled.
    assign wr_elig   = awvalid && wvalid;
    assign rd_elig   = arvalid;
    assign can_grant = (state_q == IDLE) && !reset;
    assign grant_wr  = can_grant && wr_elig
                     && (!rd_elig || !last_was_write_q);
    assign grant_rd  = can_grant && rd_elig && !grant_wr;
    assign rsp_take  = (state_q == CSR_WAIT) && csr_rsp_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_wr || grant_rd) state_d = CSR_REQ;
            end
            CSR_REQ: begin
                if (csr_req_ready) state_d = CSR_WAIT;
            end
            CSR_WAIT: begin
                if (csr_rsp_valid) state_d = write_q ? B_RSP : R_RSP;
            end
            B_RSP: begin
                if (bready) state_d = IDLE;
            end
            R_RSP: begin
                if (rready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_was_write_q <= 1'b0;
            write_q          <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            wstrb_q          <= '0;
        end else if (grant_wr || grant_rd) begin
            last_was_write_q <= grant_wr;
            write_q          <= grant_wr;
            addr_q           <= grant_wr ? awaddr : araddr;
            wdata_q          <= grant_wr ? wdata : '0;
            wstrb_q          <= grant_wr ? wstrb : '0;
        end
    end

    // Response registers only change on capture, so rdata holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            bresp_q <= RESP_OKAY;
            rresp_q <= RESP_OKAY;
            rdata_q <= '0;
        end else if (rsp_take) begin
            if (write_q) begin
                bresp_q <= resp_of(csr_rsp_error);
            end else begin
                rresp_q <= resp_of(csr_rsp_error);
                rdata_q <= csr_rsp_rdata;
            end
        end
    end

    assign awready       = grant_wr;
    assign wready        = grant_wr;
    assign arready       = grant_rd;

    assign csr_req_valid = (state_q == CSR_REQ);
    assign csr_req_write = write_q;
    assign csr_req_addr  = addr_q;
    assign csr_req_wdata = wdata_q;
    assign csr_req_wstrb = wstrb_q;

    assign bvalid        = (state_q == B_RSP);
    assign bresp         = bresp_q;
    assign rvalid        = (state_q == R_RSP);
    assign rresp         = rresp_q;
    assign rdata         = rdata_q;

endmodule

// File: tb/tb_ofs_plat_axi_mem_lite_csr_bridge.sv
// Bench for the AXI-Lite to CSR bridge: directed cases, then random
// traffic against a byte-strobed register-file model.
module tb_ofs_plat_axi_mem_lite_csr_bridge;
    import ofs_plat_axi_mem_pkg::*;

    localparam int AW    = 16;
    localparam int DW    = 64;
    localparam int SW    = DW / 8;
    localparam int BOUND = 200;

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } req_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    req_t          req_q[$];
    logic [DW-1:0] dev_mem [128];
    logic [DW-1:0] ref_mem [128];
    int            dev_rdy_dly = 0;
    int            dev_rsp_dly = 0;
    logic          dev_early = 1'b0;
    logic          dev_ovr = 1'b0;
    logic          dev_ovr_err = 1'b0;
    logic [DW-1:0] dev_ovr_rdata = '0;
    logic [DW-1:0] last_rd = '0;

    ofs_plat_axi_mem_lite_csr_bridge_if #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) bus ();

    ofs_plat_axi_mem_lite_csr_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .awvalid(bus.awvalid),
        .awready(bus.awready),
        .awaddr(bus.awaddr),
        .wvalid(bus.wvalid),
        .wready(bus.wready),
        .wdata(bus.wdata),
        .wstrb(bus.wstrb),
        .bvalid(bus.bvalid),
        .bready(bus.bready),
        .bresp(bus.bresp),
        .arvalid(bus.arvalid),
        .arready(bus.arready),
        .araddr(bus.araddr),
        .rvalid(bus.rvalid),
        .rready(bus.rready),
        .rdata(bus.rdata),
        .rresp(bus.rresp),
        .csr_req_valid(bus.csr_req_valid),
        .csr_req_ready(bus.csr_req_ready),
        .csr_req_write(bus.csr_req_write),
        .csr_req_addr(bus.csr_req_addr),
        .csr_req_wdata(bus.csr_req_wdata),
        .csr_req_wstrb(bus.csr_req_wstrb),
        .csr_rsp_valid(bus.csr_rsp_valid),
        .csr_rsp_rdata(bus.csr_rsp_rdata),
        .csr_rsp_error(bus.csr_rsp_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] d,
                                            input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < SW; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // CSR device: optional ready stall, optional early (illegal) response.
    task automatic dev_serve();
        req_t          r;
        logic [DW-1:0] rd;
        logic          er;
        r.w = bus.csr_req_write;
        r.a = bus.csr_req_addr;
        r.d = bus.csr_req_wdata;
        r.s = bus.csr_req_wstrb;
        for (int i = 0; i < dev_rdy_dly; i++) begin
            @(negedge clk);
            chk("req_stable",
                128'({bus.csr_req_valid, bus.csr_req_write, bus.csr_req_addr,
                      bus.csr_req_wdata, bus.csr_req_wstrb}),
                128'({1'b1, r.w, r.a, r.d, r.s}));
        end
        er = dev_ovr ? dev_ovr_err : (r.a[15:12] == 4'hE);
        rd = dev_ovr ? dev_ovr_rdata : dev_mem[r.a[9:3]];
        if (r.w && !er) dev_mem[r.a[9:3]] = merge(dev_mem[r.a[9:3]], r.d, r.s);
        bus.csr_req_ready = 1'b1;
        if (dev_early) begin
            bus.csr_rsp_valid = 1'b1;
            bus.csr_rsp_rdata = ~rd;
            bus.csr_rsp_error = ~er;
        end
        @(negedge clk);
        bus.csr_req_ready = 1'b0;
        bus.csr_rsp_valid = 1'b0;
        req_q.push_back(r);
        for (int i = 0; i < dev_rsp_dly; i++) begin
            @(negedge clk);
            chk("no_dup_req", 128'(bus.csr_req_valid), 128'(1'b0));
        end
        bus.csr_rsp_valid = 1'b1;
        bus.csr_rsp_rdata = rd;
        bus.csr_rsp_error = er;
        @(negedge clk);
        bus.csr_rsp_valid = 1'b0;
        bus.csr_rsp_rdata = {$urandom, $urandom};
        bus.csr_rsp_error = 1'b0;
    endtask

    initial begin
        bus.csr_req_ready = 1'b0;
        bus.csr_rsp_valid = 1'b0;
        bus.csr_rsp_rdata = '0;
        bus.csr_rsp_error = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && bus.csr_req_valid === 1'b1) dev_serve();
        end
    end

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] s, input int wdly,
                             input int bdly, input logic [1:0] exp_r);
        int t;
        bus.awvalid = 1'b1;
        bus.awaddr  = a;
        bus.wvalid  = 1'b0;
        bus.wdata   = d;
        bus.wstrb   = s;
        for (int i = 0; i < wdly; i++) begin
            #1;
            chk("aw_without_w",
                128'({bus.awready, bus.wready, bus.arready}), 128'(0));
            @(negedge clk);
        end
        bus.wvalid = 1'b1;
        #1;
        t = 0;
        while (!(bus.awready === 1'b1 && bus.wready === 1'b1) && t < BOUND) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("aw_w_grant", 128'({bus.awready, bus.wready}), 128'(2'b11));
        @(negedge clk);
        chk("aw_w_pulse", 128'({bus.awready, bus.wready}), 128'(0));
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        t = 0;
        while (bus.bvalid !== 1'b1 && t < BOUND) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < bdly; i++) begin
            chk("b_hold", 128'({bus.bvalid, bus.bresp}), 128'({1'b1, exp_r}));
            @(negedge clk);
        end
        chk("b_beat", 128'({bus.bvalid, bus.bresp}), 128'({1'b1, exp_r}));
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        chk("b_done", 128'(bus.bvalid), 128'(1'b0));
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input int rdly,
                            input logic [DW-1:0] exp_d,
                            input logic [1:0] exp_r);
        int t;
        bus.arvalid = 1'b1;
        bus.araddr  = a;
        #1;
        t = 0;
        while (bus.arready !== 1'b1 && t < BOUND) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("ar_grant", 128'(bus.arready), 128'(1'b1));
        @(negedge clk);
        chk("ar_pulse", 128'({bus.arready, bus.awready}), 128'(0));
        bus.arvalid = 1'b0;
        t = 0;
        while (bus.rvalid !== 1'b1 && t < BOUND) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < rdly; i++) begin
            chk("r_hold", 128'({bus.rvalid, bus.rresp, bus.rdata}),
                128'({1'b1, exp_r, exp_d}));
            @(negedge clk);
        end
        chk("r_beat", 128'({bus.rvalid, bus.rresp, bus.rdata}),
            128'({1'b1, exp_r, exp_d}));
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        chk("r_done", 128'(bus.rvalid), 128'(1'b0));
    endtask

    task automatic check_req(input string tag, input logic w,
                             input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] s);
        req_t r;
        chk({tag, "_count"}, 128'(req_q.size()), 128'(1));
        if (req_q.size() > 0) begin
            r = req_q.pop_front();
            chk(tag, 128'({r.w, r.a, r.d, r.s}), 128'({w, a, d, s}));
        end
        req_q.delete();
    endtask

    initial begin : main
        logic          got [4];
        int            n;
        int            t;
        req_t          r;
        logic [DW-1:0] td;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [6:0]    idx;
        logic          er;
        logic          w;

        for (int i = 0; i < 128; i++) begin
            dev_mem[i] = '0;
            ref_mem[i] = '0;
        end
        reset       = 1'b1;
        bus.awvalid = 1'b1;
        bus.awaddr  = 16'h0010;
        bus.wvalid  = 1'b1;
        td          = 64'hA5A5_0000_1111_2222;
        bus.wdata   = td;
        bus.wstrb   = 8'hFF;
        bus.arvalid = 1'b1;
        bus.araddr  = 16'h0020;
        bus.bready  = 1'b0;
        bus.rready  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs",
            128'({bus.awready, bus.wready, bus.arready, bus.bvalid,
                  bus.rvalid, bus.csr_req_valid, bus.bresp, bus.rresp,
                  bus.rdata}), 128'(0));

        // Tie from reset release: write, read, write, read.
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        reset = 1'b0;
        n = 0;
        t = 0;
        while (n < 4 && t < BOUND) begin
            #1;
            if (bus.awready === 1'b1 || bus.arready === 1'b1) begin
                chk("tie_single", 128'(bus.awready & bus.arready), 128'(0));
                got[n] = bus.awready;
                n++;
            end
            @(negedge clk);
            t++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
        chk("tie_grants", 128'(n), 128'(4));
        for (int i = 0; i < n; i++)
            chk("tie_order", 128'(got[i]), 128'(i % 2 == 0));
        repeat (10) @(negedge clk);
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        chk("tie_reqs", 128'(req_q.size()), 128'(4));
        for (int i = 0; i < 4; i++) begin
            if (req_q.size() > 0) begin
                r = req_q.pop_front();
                chk("tie_req", 128'({r.w, r.a}),
                    128'({i % 2 == 0, (i % 2 == 0) ? 16'h0010 : 16'h0020}));
            end
        end
        req_q.delete();
        ref_mem[2] = td;

        // Basic write with a delayed CSR response.
        dev_rsp_dly = 2;
        axi_write(16'h0040, 64'hDEADBEEF_00000001, 8'hFF, 0, 0, RESP_OKAY);
        check_req("wr40_req", 1'b1, 16'h0040, 64'hDEADBEEF_00000001, 8'hFF);
        ref_mem[8] = 64'hDEADBEEF_00000001;

        // Read with an error response from the CSR side.
        dev_rsp_dly   = 0;
        dev_ovr       = 1'b1;
        dev_ovr_rdata = 64'h1234;
        dev_ovr_err   = 1'b1;
        axi_read(16'h0080, 0, 64'h1234, RESP_SLVERR);
        check_req("rd80_req", 1'b0, 16'h0080, '0, '0);
        dev_ovr = 1'b0;
        last_rd = 64'h1234;

        // CSR ready and bready backpressure.
        dev_rdy_dly = 5;
        d = 64'h0123_4567_89AB_CDEF;
        axi_write(16'h0048, d, 8'h0F, 0, 3, RESP_OKAY);
        check_req("bp_req", 1'b1, 16'h0048, d, 8'h0F);
        ref_mem[9] = merge(ref_mem[9], d, 8'h0F);
        chk("rdata_hold", 128'(bus.rdata), 128'(last_rd));

        // AW waits for W before any grant.
        dev_rdy_dly = 0;
        d = 64'hFEED_FACE_CAFE_F00D;
        axi_write(16'h0050, d, 8'hF0, 10, 0, RESP_OKAY);
        check_req("aw_w_req", 1'b1, 16'h0050, d, 8'hF0);
        ref_mem[10] = merge(ref_mem[10], d, 8'hF0);
        chk("rdata_hold2", 128'(bus.rdata), 128'(last_rd));

        // Reset while waiting for the CSR response; response arrives late.
        dev_rsp_dly = 8;
        d = 64'h5555_AAAA_5555_AAAA;
        bus.awvalid = 1'b1;
        bus.awaddr  = 16'h0058;
        bus.wvalid  = 1'b1;
        bus.wdata   = d;
        bus.wstrb   = 8'hFF;
        #1;
        chk("rst_wr_grant", 128'({bus.awready, bus.wready}), 128'(2'b11));
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        t = 0;
        while (req_q.size() == 0 && t < BOUND) begin
            @(negedge clk);
            t++;
        end
        chk("rst_wait_req", 128'(req_q.size()), 128'(1));
        ref_mem[11] = d;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        last_rd = '0;
        for (int i = 0; i < 10; i++) begin
            chk("rst_no_rsp",
                128'({bus.bvalid, bus.rvalid, bus.csr_req_valid}), 128'(0));
            @(negedge clk);
        end
        req_q.delete();
        dev_rsp_dly = 0;
        axi_read(16'h0040, 1, ref_mem[8], RESP_OKAY);
        check_req("post_rst_req", 1'b0, 16'h0040, '0, '0);
        last_rd = ref_mem[8];

        // Random traffic against the register-file model.
        for (int k = 0; k < 40; k++) begin
            w   = 1'($urandom_range(0, 1));
            idx = 7'($urandom_range(0, 15));
            er  = ($urandom_range(0, 5) == 0);
            a   = {er ? 4'hE : 4'h0, 2'b00, idx, 3'b000};
            dev_rdy_dly = int'($urandom_range(0, 3));
            dev_rsp_dly = int'($urandom_range(0, 3));
            dev_early   = 1'($urandom_range(0, 1));
            if (w) begin
                d = {$urandom, $urandom};
                s = 8'($urandom_range(0, 255));
                axi_write(a, d, s, int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 3)),
                          er ? RESP_SLVERR : RESP_OKAY);
                check_req("rnd_wr_req", 1'b1, a, d, s);
                if (!er) ref_mem[idx] = merge(ref_mem[idx], d, s);
                chk("rnd_rdata_hold", 128'(bus.rdata), 128'(last_rd));
            end else begin
                axi_read(a, int'($urandom_range(0, 3)), ref_mem[idx],
                         er ? RESP_SLVERR : RESP_OKAY);
                check_req("rnd_rd_req", 1'b0, a, '0, '0);
                last_rd = ref_mem[idx];
            end
        end
        dev_early = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

endmodule
